uart_tx_scheduler: RTL

- Shares the single UART byte transmitter between two packet requesters: channel 0 (command/status replies) and channel 1 (pixel/statistics stream).
- Arbitrates round-robin at packet granularity.
- Frames each packet as SYNC, channel ID, length, payload and checksum.
- Feeds the transmitter through its DATA / DATA_READY / IDLE sampling handshake.

---
 rtl/uart_tx_scheduler_if.sv | 10 +
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the packet scheduler and the UART byte transmitter.
// The scheduler side is the master; the transmitter side is the slave.
interface uart_tx_scheduler_if;
  logic [7:0] TX_DATA;
  logic       TX_DATA_READY;
  logic       TX_IDLE;

  modport master (output TX_DATA, output TX_DATA_READY, input TX_IDLE);
  modport slave  (input TX_DATA, input TX_DATA_READY, output TX_IDLE);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-channel round-robin packet scheduler for a shared UART transmitter.
// Packet framing: SYNC, channel ID, length, payload, then an 8-bit additive checksum.
module uart_tx_scheduler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] CH0_ID    = 8'h00,
  parameter logic [7:0] CH1_ID    = 8'h01
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ0,
  input  logic [7:0]                  LEN0,
  input  logic [7:0]                  DATA0,
  output logic                        RD0,
  output logic                        GNT0,
  output logic                        DONE0,
  input  logic                        REQ1,
  input  logic [7:0]                  LEN1,
  input  logic [7:0]                  DATA1,
  output logic                        RD1,
  output logic                        GNT1,
  output logic                        DONE1,
  uart_tx_scheduler_if.master         tx,
  output logic                        BUSY
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_CHID    = 3'd2;
  localparam logic [2:0] ST_LENB    = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;

  logic [2:0] state_q, state_d;
  logic       sel_q, sel_d;     // granted channel
  logic       last_q, last_d;   // last channel served
  logic [7:0] len_q, len_d;     // latched length, then remaining payload count
  logic [7:0] csum_q, csum_d;

  logic       busy;
  logic       accept;
  logic       rd_pulse;
  logic       done_pulse;
  logic [7:0] tx_byte;

  assign busy   = (state_q != ST_IDLE);
  assign accept = busy & tx.TX_IDLE;

  always_comb begin
    unique case (state_q)
      ST_SYNC:    tx_byte = SYNC_BYTE;
      ST_CHID:    tx_byte = sel_q ? CH1_ID : CH0_ID;
      ST_LENB:    tx_byte = len_q;
      ST_PAYLOAD: tx_byte = sel_q ? DATA1 : DATA0;
      ST_CSUM:    tx_byte = csum_q;
      default:    tx_byte = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    len_d      = len_q;
    csum_d     = csum_q;
    rd_pulse   = 1'b0;
    done_pulse = 1'b0;

    // Every accepted byte except SYNC and the checksum itself feeds the sum.
    if (accept && (state_q == ST_CHID || state_q == ST_LENB || state_q == ST_PAYLOAD))
      csum_d = csum_q + tx_byte;

    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          sel_d   = (REQ0 && REQ1) ? ~last_q : REQ1;
          len_d   = sel_d ? LEN1 : LEN0;
          csum_d  = '0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: if (accept) state_d = ST_CHID;
      ST_CHID: if (accept) state_d = ST_LENB;
      ST_LENB: if (accept) state_d = (len_q != '0) ? ST_PAYLOAD : ST_CSUM;
      ST_PAYLOAD: begin
        if (accept) begin
          rd_pulse = 1'b1;
          len_d    = len_q - 8'd1;
          if (len_q == 8'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          done_pulse = 1'b1;
          last_d     = sel_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
    end
  end

  // Pulses are suppressed during reset so an abandoned packet reports nothing.
  assign RD0   = rd_pulse   & ~sel_q & ~RST;
  assign RD1   = rd_pulse   &  sel_q & ~RST;
  assign DONE0 = done_pulse & ~sel_q & ~RST;
  assign DONE1 = done_pulse &  sel_q & ~RST;
  assign GNT0  = busy & ~sel_q;
  assign GNT1  = busy &  sel_q;
  assign BUSY  = busy;

  assign tx.TX_DATA       = tx_byte;
  assign tx.TX_DATA_READY = busy;

endmodule
